switch_ingress_dest_lookup: RTL and testbench
=============================================

// Module: switch_ingress_dest_lookup
// PURPOSE
//   Per-port ingress stage in front of the output-queued crossbar. Parses destination MAC from the
//   first beat of each frame and looks it up in a software-programmed table. Drives the one-hot
//   RADIX-bit tdest bitmap that the crossbar uses to select output ports, then forwards the frame.
//   One instance per switch port. Frames with no legal destination are dropped and counted.
// PARAMETERS
//   AXIS_DATA_WIDTH   64                  data bus width; must be >= 48
//   AXIS_KEEP_WIDTH   AXIS_DATA_WIDTH/8   tkeep width
//   AXIS_ID_ENABLE    1                   pass tid through (0: m_axis_tid driven 0)
//   AXIS_ID_WIDTH     8                   tid width
//   AXIS_USER_ENABLE  1                   pass tuser through (0: m_axis_tuser driven 0)
//   AXIS_USER_WIDTH   17                  tuser width
//   RADIX             4                   switch port count = tdest bitmap width
//   PORT_INDEX        0                   this port's index; its bit is always cleared from tdest
//   TABLE_SIZE        8                   MAC table entries (power of 2, >= 2)
// PORTS
//   clk            in   1                  clock, all logic rising edge
//   rst_n          in   1                  asynchronous active-low reset
//   s_axis_tdata   in   AXIS_DATA_WIDTH    frame data; byte 0 (tdata[7:0]) = first wire byte
//   s_axis_tkeep   in   AXIS_KEEP_WIDTH    byte enables
//   s_axis_tvalid  in   1                  input beat valid
//   s_axis_tready  out  1                  input beat accepted
//   s_axis_tlast   in   1                  last beat of frame
//   s_axis_tid     in   AXIS_ID_WIDTH      passed through
//   s_axis_tuser   in   AXIS_USER_WIDTH    passed through
//   m_axis_tdata   out  AXIS_DATA_WIDTH    to crossbar input
//   m_axis_tkeep   out  AXIS_KEEP_WIDTH
//   m_axis_tvalid  out  1
//   m_axis_tready  in   1
//   m_axis_tlast   out  1
//   m_axis_tid     out  AXIS_ID_WIDTH
//   m_axis_tdest   out  RADIX              one-hot/multi-hot output-port bitmap, constant per frame
//   m_axis_tuser   out  AXIS_USER_WIDTH
//   cfg_wr_en      in   1                  table write strobe, single cycle
//   cfg_wr_addr    in   $clog2(TABLE_SIZE) entry index
//   cfg_wr_valid   in   1                  entry valid bit (0 invalidates entry)
//   cfg_wr_mac     in   48                 entry MAC; byte 0 in [7:0], same order as tdata
//   cfg_wr_mask    in   RADIX              entry output-port bitmap
//   drop_count     out  32                 dropped-frame count, saturating
// BEHAVIOUR
//   - Reset (async, rst_n=0): m_axis_tvalid=0; all other m_axis_* = 0; state=HEAD; drop_count=0;
//     all table valid bits=0. A partial frame in flight is discarded. The first beat after reset
//     is treated as a frame head.
//   - FSM states:
//       HEAD: waiting for first beat.
//       FWD:  forwarding the rest of the frame.
//       DROP: discarding the rest of the frame.
//   - On a HEAD beat accepted: dmac = tdata[47:0].
//       if dmac[0] (group bit): dest = all ones
//       elif a valid entry matches: dest = mask of the lowest-index matching entry
//       else (flood): dest = all ones
//     Then dest[PORT_INDEX] is cleared.
//       dest != 0: beat is forwarded; dest is latched for the frame; next state is FWD
//         (HEAD if tlast).
//       dest == 0: beat is discarded; next state is DROP (HEAD if tlast, with drop_count++).
//   - Lookup is combinational on the HEAD beat. Latency is 1 cycle: a single output register stage
//     holds data, control and tdest.
//   - Handshake (HEAD/FWD): s_axis_tready = !m_axis_tvalid || m_axis_tready. Full throughput, no
//     bubbles. Output holds stable while m_axis_tvalid && !m_axis_tready.
//   - DROP: s_axis_tready=1 and nothing is emitted. On the tlast beat: drop_count++ (saturating at
//     32'hFFFFFFFF), next state HEAD.
//   - Config write in the same cycle as a HEAD lookup: the lookup sees pre-write contents; the
//     write takes effect next cycle. Writes mid-frame never alter the latched tdest of the current
//     frame.
//   - Single-beat frames are legal. A HEAD beat with tlast may be followed back-to-back by the next
//     head.
//   - m_axis_tdest only changes on a HEAD-beat transfer into the output register.
// STRUCTURE
//   - Package switch_pkg holds:
//       - MAC_WIDTH=48
//       - the cfg address width function (clog2 of TABLE_SIZE)
//       - a function for the broadcast mask excluding a port index.
//     The package is shared with other port-side blocks.
//   - Sub-module switch_mac_table: TABLE_SIZE registered entries {valid, mac, mask}, write port,
//     and a combinational priority-match lookup (hit, mask). The top level holds the FSM, the
//     output register and the counter.
// TESTING
//   - Program entry 2 with mac 02:00:00:00:00:0A, mask 4'b0100; PORT_INDEX=0. Send a 3-beat frame
//     to that MAC -> 3 output beats, tdest=4'b0100 on every beat, 1-cycle latency.
//   - Send to an unknown unicast MAC -> tdest=4'b1110.
//     Send to ff:ff:ff:ff:ff:ff -> tdest=4'b1110.
//   - Program mask 4'b0001 (own port only) and send a 2-frame burst -> no output, drop_count=2,
//     s_axis_tready held 1.
//   - Hold m_axis_tready=0 for 5 cycles mid-frame -> output beat stable, s_axis_tready=0, no data
//     loss or duplication after release.
//   - Rewrite entry 2 mask to 4'b1000 mid-frame -> current frame keeps 4'b0100, next frame
//     gets 4'b1000. A write coincident with the head beat -> the old mask is used.
//   - Assert rst_n=0 mid-frame with m_axis_tvalid=1 -> tvalid drops immediately, table cleared.
//     After release, the next beat is a head and floods (4'b1110).

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch port-side blocks.
package switch_pkg;

  localparam int MAC_WIDTH = 48;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } ingress_state_t;

  // Width of a table index for a table of the given size.
  function automatic int cfg_addr_width(input int table_size);
    return $clog2(table_size);
  endfunction

  // All ports of a radix-wide switch except the given port; bits above radix stay 0.
  function automatic logic [31:0] bcast_mask(input int radix, input int port_index);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < radix && i != port_index) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/switch_mac_table.sv
// Software-programmed destination MAC table with lowest-index priority match.
module switch_mac_table
  import switch_pkg::*;
#(
  parameter int TABLE_SIZE = 8,
  parameter int RADIX      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en,
  input  logic [cfg_addr_width(TABLE_SIZE)-1:0] wr_addr,
  input  logic                                  wr_valid,
  input  logic [MAC_WIDTH-1:0]                  wr_mac,
  input  logic [RADIX-1:0]                      wr_mask,
  input  logic [MAC_WIDTH-1:0]                  lookup_mac,
  output logic                                  hit,
  output logic [RADIX-1:0]                      hit_mask
);

  logic [TABLE_SIZE-1:0] valid_q;
  logic [MAC_WIDTH-1:0]  mac_q  [TABLE_SIZE];
  logic [RADIX-1:0]      mask_q [TABLE_SIZE];

  // Entry storage; a write becomes visible to lookups on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < TABLE_SIZE; i++) begin
        mac_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_addr] <= wr_valid;
      mac_q[wr_addr]   <= wr_mac;
      mask_q[wr_addr]  <= wr_mask;
    end
  end

  // Priority match: scanning downward lets the lowest matching index win.
  always_comb begin
    hit      = 1'b0;
    hit_mask = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && mac_q[i] == lookup_mac) begin
        hit      = 1'b1;
        hit_mask = mask_q[i];
      end
    end
  end

endmodule

// File: rtl/switch_ingress_dest_lookup.sv
// Per-port ingress stage: destination lookup on the frame head, tdest tagging and drop of
// frames that have nowhere legal to go.
//
//   state   | meaning
//   --------+--------------------------------------------
//   ST_HEAD | waiting for the first beat of a frame
//   ST_FWD  | forwarding the rest of an accepted frame
//   ST_DROP | discarding the rest of a dropped frame
module switch_ingress_dest_lookup
  import switch_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_ID_ENABLE   = 1,
  parameter int AXIS_ID_WIDTH    = 8,
  parameter int AXIS_USER_ENABLE = 1,
  parameter int AXIS_USER_WIDTH  = 17,
  parameter int RADIX            = 4,
  parameter int PORT_INDEX       = 0,
  parameter int TABLE_SIZE       = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [AXIS_ID_WIDTH-1:0]              s_axis_tid,
  input  logic [AXIS_USER_WIDTH-1:0]            s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [AXIS_ID_WIDTH-1:0]              m_axis_tid,
  output logic [RADIX-1:0]                      m_axis_tdest,
  output logic [AXIS_USER_WIDTH-1:0]            m_axis_tuser,
  input  logic                                  cfg_wr_en,
  input  logic [cfg_addr_width(TABLE_SIZE)-1:0] cfg_wr_addr,
  input  logic                                  cfg_wr_valid,
  input  logic [MAC_WIDTH-1:0]                  cfg_wr_mac,
  input  logic [RADIX-1:0]                      cfg_wr_mask,
  output logic [31:0]                           drop_count
);

  localparam logic [31:0]      BCAST32 = bcast_mask(RADIX, PORT_INDEX);
  localparam logic [RADIX-1:0] BCAST   = BCAST32[RADIX-1:0];

  ingress_state_t state, state_next;

  logic [MAC_WIDTH-1:0] dmac;
  logic                 tbl_hit;
  logic [RADIX-1:0]     tbl_mask;
  logic [RADIX-1:0]     dest;
  logic                 accept;
  logic                 out_upd;
  logic                 head_load;
  logic                 load;
  logic                 drop_evt;

  assign dmac = s_axis_tdata[MAC_WIDTH-1:0];

  switch_mac_table #(
    .TABLE_SIZE (TABLE_SIZE),
    .RADIX      (RADIX)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (cfg_wr_en),
    .wr_addr    (cfg_wr_addr),
    .wr_valid   (cfg_wr_valid),
    .wr_mac     (cfg_wr_mac),
    .wr_mask    (cfg_wr_mask),
    .lookup_mac (dmac),
    .hit        (tbl_hit),
    .hit_mask   (tbl_mask)
  );

  // Group addresses and misses flood; our own port is never a destination.
  always_comb begin
    dest = BCAST;
    if (!dmac[0] && tbl_hit) dest = tbl_mask & BCAST;
  end

  // DROP swallows beats regardless of the output stage so the crossbar never stalls it.
  assign out_upd       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_DROP) ? 1'b1 : out_upd;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign head_load     = accept && (state == ST_HEAD) && (dest != '0);
  assign load          = head_load || (accept && (state == ST_FWD));
  assign drop_evt      = accept && s_axis_tlast &&
                         (((state == ST_HEAD) && (dest == '0)) || (state == ST_DROP));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HEAD;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_HEAD: if (accept && !s_axis_tlast) state_next = (dest != '0) ? ST_FWD : ST_DROP;
      ST_FWD:  if (accept && s_axis_tlast)  state_next = ST_HEAD;
      ST_DROP: if (accept && s_axis_tlast)  state_next = ST_HEAD;
      default: state_next = ST_HEAD;
    endcase
  end

  // Output register; tdest is only reloaded by a head beat so it stays constant per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= '0;
      m_axis_tdest  <= '0;
    end else if (out_upd) begin
      m_axis_tvalid <= load;
      if (load) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tid   <= (AXIS_ID_ENABLE != 0) ? s_axis_tid : '0;
        m_axis_tuser <= (AXIS_USER_ENABLE != 0) ? s_axis_tuser : '0;
        if (head_load) m_axis_tdest <= dest;
      end
    end
  end

  // Saturating dropped-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              drop_count <= '0;
    else if (drop_evt && drop_count != '1)   drop_count <= drop_count + 32'd1;
  end

endmodule

// File: tb/tb_switch_ingress_dest_lookup.sv
module tb_switch_ingress_dest_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tid;
  logic [16:0] s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [3:0]  m_axis_tdest;
  logic [16:0] m_axis_tuser;
  logic        cfg_wr_en;
  logic [2:0]  cfg_wr_addr;
  logic        cfg_wr_valid;
  logic [47:0] cfg_wr_mac;
  logic [3:0]  cfg_wr_mask;
  logic [31:0] drop_count;

  int checks = 0;
  int errors = 0;

  // 02:00:00:00:00:0A with byte 0 in bits [7:0]
  localparam logic [47:0] MAC_A   = 48'h0A00_0000_0002;
  localparam logic [47:0] MAC_UNK = 48'h0B00_0000_0004;
  localparam logic [47:0] MAC_BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_OWN = 48'h0C00_0000_0006;

  switch_ingress_dest_lookup dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_valid  (cfg_wr_valid),
    .cfg_wr_mac    (cfg_wr_mac),
    .cfg_wr_mask   (cfg_wr_mask),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat at the falling edge, return 1 ns after the next rising edge.
  task automatic step(input logic [63:0] d, input logic last);
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic v, input logic [47:0] mac,
                           input logic [3:0] mask);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_valid = v; cfg_wr_mac = mac; cfg_wr_mask = mask;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = 8'hFF; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tid = 8'h5A; s_axis_tuser = 17'h1ABCD; m_axis_tready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_valid = 1'b0; cfg_wr_mac = '0; cfg_wr_mask = '0;
    #12;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("rst_tdest",  64'(m_axis_tdest),  64'h0);
    chk("rst_drops",  64'(drop_count),    64'h0);
    chk("rst_ready",  64'(s_axis_tready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Programmed unicast, 3-beat frame
    cfg_write(3'd2, 1'b1, MAC_A, 4'b0100);
    step({16'h1111, MAC_A}, 1'b0);
    chk("a1_valid", 64'(m_axis_tvalid), 64'h1);
    chk("a1_data",  m_axis_tdata,       {16'h1111, MAC_A});
    chk("a1_dest",  64'(m_axis_tdest),  64'h4);
    chk("a1_tid",   64'(m_axis_tid),    64'h5A);
    chk("a1_tuser", 64'(m_axis_tuser),  64'h1ABCD);
    chk("a1_tkeep", 64'(m_axis_tkeep),  64'hFF);
    step(64'h2222_2222_2222_2222, 1'b0);
    chk("a2_data",  m_axis_tdata,       64'h2222_2222_2222_2222);
    chk("a2_dest",  64'(m_axis_tdest),  64'h4);
    chk("a2_last",  64'(m_axis_tlast),  64'h0);
    step(64'h3333_3333_3333_3333, 1'b1);
    chk("a3_data",  m_axis_tdata,       64'h3333_3333_3333_3333);
    chk("a3_dest",  64'(m_axis_tdest),  64'h4);
    chk("a3_last",  64'(m_axis_tlast),  64'h1);

    // Unknown unicast and broadcast, back to back single-beat frames
    step({16'h4444, MAC_UNK}, 1'b1);
    chk("unk_data", m_axis_tdata,       {16'h4444, MAC_UNK});
    chk("unk_dest", 64'(m_axis_tdest),  64'hE);
    step({16'h5555, MAC_BC}, 1'b1);
    chk("bc_valid", 64'(m_axis_tvalid), 64'h1);
    chk("bc_dest",  64'(m_axis_tdest),  64'hE);
    idle();
    chk("gap_valid", 64'(m_axis_tvalid), 64'h0);

    // Own-port-only entry: two 2-beat frames dropped
    cfg_write(3'd3, 1'b1, MAC_OWN, 4'b0001);
    for (int f = 0; f < 2; f++) begin
      step({16'h6666, MAC_OWN}, 1'b0);
      chk("drop_h_valid", 64'(m_axis_tvalid), 64'h0);
      chk("drop_h_ready", 64'(s_axis_tready), 64'h1);
      step(64'h7777_7777_7777_7777, 1'b1);
      chk("drop_t_valid", 64'(m_axis_tvalid), 64'h0);
      chk("drop_t_ready", 64'(s_axis_tready), 64'h1);
    end
    chk("drop_count2", 64'(drop_count), 64'h2);

    // Backpressure for 5 cycles mid-frame
    step({16'h8888, MAC_A}, 1'b0);
    chk("bp1_data", m_axis_tdata, {16'h8888, MAC_A});
    @(negedge clk);
    m_axis_tready = 1'b0;
    s_axis_tdata  = 64'h9999_9999_9999_9999;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", 64'(s_axis_tready), 64'h0);
      chk("bp_hold",  m_axis_tdata,       {16'h8888, MAC_A});
      chk("bp_valid", 64'(m_axis_tvalid), 64'h1);
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp2_data", m_axis_tdata, 64'h9999_9999_9999_9999);
    step(64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    chk("bp3_data", m_axis_tdata, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("bp3_last", 64'(m_axis_tlast), 64'h1);
    idle();
    chk("bp_end_valid", 64'(m_axis_tvalid), 64'h0);

    // Mid-frame rewrite keeps the latched tdest
    step({16'hBBBB, MAC_A}, 1'b0);
    chk("mf_h_dest", 64'(m_axis_tdest), 64'h4);
    @(negedge clk);
    s_axis_tdata = 64'hCCCC_CCCC_CCCC_CCCC; s_axis_tlast = 1'b1;
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'd2; cfg_wr_valid = 1'b1; cfg_wr_mac = MAC_A;
    cfg_wr_mask = 4'b1000;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    chk("mf_t_dest", 64'(m_axis_tdest), 64'h4);
    chk("mf_t_data", m_axis_tdata,      64'hCCCC_CCCC_CCCC_CCCC);
    step({16'hDDDD, MAC_A}, 1'b1);
    chk("new_dest", 64'(m_axis_tdest), 64'h8);

    // Write coincident with a head beat: lookup sees the old mask
    @(negedge clk);
    s_axis_tdata = {16'hEEEE, MAC_A}; s_axis_tlast = 1'b1;
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'd2; cfg_wr_mask = 4'b0010;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    chk("coin_dest", 64'(m_axis_tdest), 64'h8);
    step({16'hF0F0, MAC_A}, 1'b1);
    chk("after_coin_dest", 64'(m_axis_tdest), 64'h2);
    chk("drop_count_pre_rst", 64'(drop_count), 64'h2);

    // Reset mid-frame
    step({16'h1212, MAC_A}, 1'b0);
    chk("pre_rst_valid", 64'(m_axis_tvalid), 64'h1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(m_axis_tvalid), 64'h0);
    chk("mrst_dest",  64'(m_axis_tdest),  64'h0);
    chk("mrst_drops", 64'(drop_count),    64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step({16'h3434, MAC_A}, 1'b1);
    chk("post_rst_valid", 64'(m_axis_tvalid), 64'h1);
    chk("post_rst_dest",  64'(m_axis_tdest),  64'hE);
    chk("post_rst_data",  m_axis_tdata,       {16'h3434, MAC_A});
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
